game_countdown_timer: RTL and testbench

Level countdown timer for the game. It sits directly upstream of the terminal-count edge detector. It divides the system clock into 1-second ticks and counts a BCD seconds value down to 00. It then raises a level tc that the downstream stage turns into a single end-of-time event. It also supplies the BCD digits to the score/timer display and supports start, pause and bonus-time add from game logic.

---
 rtl/game_countdown_timer.sv | 136 +++++++++++++
 tb/tb_game_countdown_timer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// Level countdown timer: divides clk into game seconds, counts a BCD
// seconds value down to 00 and holds tc high once expired. Supports
// start/reload, pause with partial-second retention and bonus time.
module game_countdown_timer #(
  parameter int TICKS_PER_SEC = 31500000,
  parameter int START_SEC     = 99,
  parameter int BONUS_SEC     = 10,
  parameter int MAX_SEC       = 99
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       pause,
  input  logic       addTime,
  output logic       tc,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic       running,
  output logic       oneSecPulse
);

  // A single-tick divider still needs one bit to hold the (always zero) count.
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    START_CNT  = 7'(START_SEC);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;       // remaining seconds, binary 0..99
  logic [PW-1:0] presc_q, presc_d;
  logic          tc_q, tc_d;
  logic          run_q, run_d;
  logic          pulse_q, pulse_d;
  logic [3:0]    tens_q, ones_q;
  logic          tick;
  logic [6:0]    dec_cnt;

  // Saturating bonus add; the sum can reach 198 so it is formed in 8 bits.
  function automatic logic [6:0] sat_add(input logic [6:0] base);
    logic [7:0] sum;
    sum = {1'b0, base} + 8'(BONUS_SEC);
    return (sum > 8'(MAX_SEC)) ? 7'(MAX_SEC) : sum[6:0];
  endfunction

  assign tick    = (presc_q == PRESC_LAST);
  assign dec_cnt = cnt_q - 7'd1;

  // Next-state decode: start beats pause, pause beats tick/addTime.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    tc_d    = tc_q;
    run_d   = run_q;
    pulse_d = 1'b0;
    if (start) begin
      state_d = RUN;
      cnt_d   = START_CNT;
      presc_d = '0;
      tc_d    = 1'b0;
      run_d   = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (pause) begin
            // Prescaler is left alone so the partial second survives.
            state_d = PAUSED;
            run_d   = 1'b0;
            if (addTime) cnt_d = sat_add(cnt_q);
          end else if (tick) begin
            presc_d = '0;
            pulse_d = 1'b1;
            if (addTime) begin
              // Bonus on the tick edge rescues a count that would hit 00.
              cnt_d = sat_add(dec_cnt);
            end else begin
              cnt_d = dec_cnt;
              if (dec_cnt == 7'd0) begin
                state_d = EXPIRED;
                tc_d    = 1'b1;
                run_d   = 1'b0;
              end
            end
          end else begin
            presc_d = presc_q + PW'(1);
            if (addTime) cnt_d = sat_add(cnt_q);
          end
        end
        PAUSED: begin
          if (addTime) cnt_d = sat_add(cnt_q);
          if (!pause) begin
            state_d = RUN;
            run_d   = 1'b1;
          end
        end
        default: ; // IDLE and EXPIRED hold everything until start
      endcase
    end
  end

  // State and registered outputs; BCD digits are derived from the next count.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= START_CNT;
      presc_q <= '0;
      tc_q    <= 1'b0;
      run_q   <= 1'b0;
      pulse_q <= 1'b0;
      tens_q  <= 4'(START_CNT / 7'd10);
      ones_q  <= 4'(START_CNT % 7'd10);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      run_q   <= run_d;
      pulse_q <= pulse_d;
      tens_q  <= 4'(cnt_d / 7'd10);
      ones_q  <= 4'(cnt_d % 7'd10);
    end
  end

  assign tc          = tc_q;
  assign running     = run_q;
  assign oneSecPulse = pulse_q;
  assign secTens     = tens_q;
  assign secOnes     = ones_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with a short second (4 clocks),
// START_SEC=3, BONUS_SEC=10, MAX_SEC=99.
module tb_game_countdown_timer;

  logic       clk = 1'b0;
  logic       resetN, start, pause, addTime;
  logic       tc, running, oneSecPulse;
  logic [3:0] secTens, secOnes;

  int n_checks = 0;
  int n_pass   = 0;

  game_countdown_timer #(
    .TICKS_PER_SEC(4),
    .START_SEC    (3),
    .BONUS_SEC    (10),
    .MAX_SEC      (99)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .pause      (pause),
    .addTime    (addTime),
    .tc         (tc),
    .secTens    (secTens),
    .secOnes    (secOnes),
    .running    (running),
    .oneSecPulse(oneSecPulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Checks the full output set; cnt is the expected BCD count as two hex nibbles.
  task automatic check_all(input string tag, input logic [7:0] cnt, input logic e_tc,
                           input logic e_run, input logic e_pulse);
    check({tag, ".count"}, {secTens, secOnes}, cnt);
    check({tag, ".tc"}, {7'd0, tc}, {7'd0, e_tc});
    check({tag, ".running"}, {7'd0, running}, {7'd0, e_run});
    check({tag, ".pulse"}, {7'd0, oneSecPulse}, {7'd0, e_pulse});
    $display("txn %-14s count=%h%h tc=%b run=%b pulse=%b", tag, secTens, secOnes, tc, running, oneSecPulse);
  endtask

  // One clock edge; outputs are settled and inputs may be changed afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sat_cnt [10];
  logic       sat_pls [10];

  initial begin
    resetN = 1'b0; start = 1'b0; pause = 1'b0; addTime = 1'b0;
    repeat (3) step();
    check_all("reset", 8'h03, 1'b0, 1'b0, 1'b0);

    // IDLE ignores addTime and pause
    resetN = 1'b1; addTime = 1'b1; pause = 1'b1;
    repeat (2) step();
    addTime = 1'b0; pause = 1'b0;
    check_all("idle_ign", 8'h03, 1'b0, 1'b0, 1'b0);

    // Basic countdown: pulses every 4 cycles, expiry at cycle 12
    start = 1'b1; step(); start = 1'b0;
    check_all("start", 8'h03, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      step();
      check_all($sformatf("run_c%0d", c), 8'(3 - c / 4), (c == 12), (c < 12), (c % 4 == 0));
    end

    // EXPIRED holds 00/tc; addTime and pause ignored
    for (int i = 0; i < 20; i++) begin
      addTime = (i < 3);
      pause   = (i >= 5 && i < 10);
      step();
      check_all($sformatf("exp_%0d", i), 8'h00, 1'b1, 1'b0, 1'b0);
    end
    addTime = 1'b0; pause = 1'b0;

    // Restart from EXPIRED
    start = 1'b1; step(); start = 1'b0;
    check_all("restart", 8'h03, 1'b0, 1'b1, 1'b0);

    // Bonus to 13, then pause after 2 prescaler cycles for 10 cycles
    addTime = 1'b1; step(); addTime = 1'b0;
    check_all("add13", 8'h13, 1'b0, 1'b1, 1'b0);
    step();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_all($sformatf("paused_%0d", i), 8'h13, 1'b0, 1'b0, 1'b0);
    end
    pause = 1'b0;
    step(); check_all("resume0", 8'h13, 1'b0, 1'b1, 1'b0);
    step(); check_all("resume1", 8'h13, 1'b0, 1'b1, 1'b0);
    step(); check_all("resume_tick", 8'h12, 1'b0, 1'b1, 1'b1);
    repeat (8) step();
    check_all("cnt10", 8'h10, 1'b0, 1'b1, 1'b1);
    repeat (4) step();
    check_all("borrow09", 8'h09, 1'b0, 1'b1, 1'b1);

    // addTime coincident with a tick: 09-1+10 = 18
    repeat (3) step();
    addTime = 1'b1; step();
    check_all("add_tick", 8'h18, 1'b0, 1'b1, 1'b1);

    // Continuous addTime up to saturation at 99
    sat_cnt = '{8'h28, 8'h38, 8'h48, 8'h57, 8'h67, 8'h77, 8'h87, 8'h96, 8'h99, 8'h99};
    sat_pls = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step();
      check_all($sformatf("sat_%0d", i), sat_cnt[i], 1'b0, 1'b1, sat_pls[i]);
    end
    addTime = 1'b0;
    step(); check_all("sat_hold", 8'h99, 1'b0, 1'b1, 1'b0);
    step(); check_all("sat_dec", 8'h98, 1'b0, 1'b1, 1'b1);

    // addTime on the 01->00 tick rescues to 10, no expiry
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    check_all("at01", 8'h01, 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    addTime = 1'b1; step(); addTime = 1'b0;
    check_all("rescue", 8'h10, 1'b0, 1'b1, 1'b1);
    step(); check_all("rescue_hold", 8'h10, 1'b0, 1'b1, 1'b0);

    // start coincident with the expiring tick wins
    start = 1'b1; step(); start = 1'b0;
    repeat (8) step();
    check_all("at01b", 8'h01, 1'b0, 1'b1, 1'b1);
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;
    check_all("start_vs_exp", 8'h03, 1'b0, 1'b1, 1'b0);
    step(); check_all("start_vs_exp1", 8'h03, 1'b0, 1'b1, 1'b0);

    // Synchronous reset mid-RUN at count 02
    repeat (3) step();
    check_all("pre_reset", 8'h02, 1'b0, 1'b1, 1'b1);
    resetN = 1'b0; step(); resetN = 1'b1;
    check_all("mid_reset", 8'h03, 1'b0, 1'b0, 1'b0);
    pause = 1'b1; addTime = 1'b1;
    repeat (8) step();
    pause = 1'b0; addTime = 1'b0;
    check_all("post_reset", 8'h03, 1'b0, 1'b0, 1'b0);

    // A resetN glitch between edges has no effect
    start = 1'b1; step(); start = 1'b0;
    #2 resetN = 1'b0;
    #2 resetN = 1'b1;
    repeat (4) step();
    check_all("glitch", 8'h02, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
